// File: rtl/dct_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dct_pkg
//  Description : Shared constants and types for the 8-point 2-D DCT datapath
//                (transform size, coefficient width, row/column vector type
//                and the transpose-bank occupancy state).
//  Revision    : 1.0 - initial release
// ============================================================================
package dct_pkg;

    localparam int DCT_N      = 8;
    localparam int DCT_COEF_W = 16;
    localparam int DCT_IDX_W  = 3;

    // One row or one column of signed coefficients.
    typedef logic signed [DCT_COEF_W-1:0] dct_vec_t [DCT_N];

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL  = 2'd1,
        FULL  = 2'd2,
        DRAIN = 2'd3
    } bank_state_e;

endpackage : dct_pkg
`default_nettype wire

// File: rtl/dct_transpose_if.sv
`default_nettype none
// ============================================================================
//  Module      : dct_transpose_if
//  Description : Streaming row-in / column-out bundle for the DCT transpose
//                buffer.
//                s_valid/s_ready/s_data       : row input stream
//                m_valid/m_ready/m_data       : column output stream
//                m_col                        : index of presented column
//                m_last                       : high with m_col == 7
//                modport slave  - transpose buffer side
//                modport master - producer/consumer side
//  Revision    : 1.0 - initial release
// ============================================================================
interface dct_transpose_if
    import dct_pkg::*;
#(
    parameter int DATA_W = DCT_COEF_W
);
    logic                     s_valid;
    logic                     s_ready;
    logic signed [DATA_W-1:0] s_data [DCT_N];
    logic                     m_valid;
    logic                     m_ready;
    logic signed [DATA_W-1:0] m_data [DCT_N];
    logic [DCT_IDX_W-1:0]     m_col;
    logic                     m_last;

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, m_col, m_last
    );

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, m_col, m_last
    );

endinterface : dct_transpose_if
`default_nettype wire

// File: rtl/dct_tr_bank.sv
`default_nettype none
// ============================================================================
//  Module      : dct_tr_bank
//  Description : One 8x8 coefficient register bank. Written a whole row at a
//                time, read a whole column at a time (combinational).
//  Ports       : clk, rst     - clock, asynchronous active-high reset
//                we, wr_row   - row write strobe and row index
//                wr_data      - row to store
//                rd_col       - column index
//                rd_data      - column read data (element r = row r)
//  Revision    : 1.0 - initial release
// ============================================================================
module dct_tr_bank
    import dct_pkg::*;
#(
    parameter int DATA_W = DCT_COEF_W
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     we,
    input  wire logic [DCT_IDX_W-1:0]     wr_row,
    input  wire logic signed [DATA_W-1:0] wr_data [DCT_N],
    input  wire logic [DCT_IDX_W-1:0]     rd_col,
    output logic signed [DATA_W-1:0]      rd_data [DCT_N]
);

    logic signed [DATA_W-1:0] r_mem [DCT_N][DCT_N];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < DCT_N; r++) begin
                for (int c = 0; c < DCT_N; c++) begin
                    r_mem[r][c] <= '0;
                end
            end
        end else if (we) begin
            for (int c = 0; c < DCT_N; c++) begin
                r_mem[wr_row][c] <= wr_data[c];
            end
        end
    end

    always_comb begin
        for (int r = 0; r < DCT_N; r++) begin
            rd_data[r] = r_mem[r][rd_col];
        end
    end

endmodule : dct_tr_bank
`default_nettype wire

// File: rtl/dct_transpose.sv
`default_nettype none
// ============================================================================
//  Module      : dct_transpose
//  Description : Row-to-column transpose buffer between the row and column
//                passes of the 8x8 DCT. Collects eight rows into a bank,
//                then emits the bank column by column.
//  Ports       : clk, rst - clock, asynchronous active-high reset
//                bus      - dct_transpose_if.slave (row in, column out)
//  Config      : DCT_TRANSPOSE_PINGPONG_EN - two banks, fill one while the
//                other drains; otherwise a single bank.
//  Revision    : 1.0 - initial release
// ============================================================================
module dct_transpose
    import dct_pkg::*;
#(
    parameter int DATA_W = DCT_COEF_W
) (
    input  wire logic       clk,
    input  wire logic       rst,
    dct_transpose_if.slave  bus
);

`ifdef DCT_TRANSPOSE_PINGPONG_EN
    localparam int NUM_BANKS = 2;
`else
    localparam int NUM_BANKS = 1;
`endif

    bank_state_e              r_bank_st     [NUM_BANKS];
    bank_state_e              w_bank_st_nxt [NUM_BANKS];
    bank_state_e              w_wr_st;
    bank_state_e              w_rd_st;
    logic [DCT_IDX_W-1:0]     r_wr_row;
    logic [DCT_IDX_W-1:0]     r_rd_col;
    logic                     w_wr_bank;
    logic                     w_rd_bank;
    logic                     w_wr_fire;
    logic                     w_rd_fire;
    logic signed [DATA_W-1:0] w_bank_rd [NUM_BANKS][DCT_N];

    // ---------------------------------------------------------------- pointers
`ifdef DCT_TRANSPOSE_PINGPONG_EN
    logic r_wr_bank;
    logic r_rd_bank;

    // Bank pointers flip on the last row / last column of a block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
        end else begin
            if (w_wr_fire && (r_wr_row == 3'd7)) begin
                r_wr_bank <= ~r_wr_bank;
            end
            if (w_rd_fire && (r_rd_col == 3'd7)) begin
                r_rd_bank <= ~r_rd_bank;
            end
        end
    end

    assign w_wr_bank = r_wr_bank;
    assign w_rd_bank = r_rd_bank;
`else
    assign w_wr_bank = 1'b0;
    assign w_rd_bank = 1'b0;
`endif

    // ------------------------------------------------------- selected states
    always_comb begin
        w_wr_st = EMPTY;
        w_rd_st = EMPTY;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (w_wr_bank == 1'(b)) w_wr_st = r_bank_st[b];
            if (w_rd_bank == 1'(b)) w_rd_st = r_bank_st[b];
        end
    end

    // Handshake qualifiers come from registered bank state only.
    assign bus.s_ready = (w_wr_st == EMPTY) || (w_wr_st == FILL);
    assign bus.m_valid = (w_rd_st == FULL)  || (w_rd_st == DRAIN);
    assign w_wr_fire   = bus.s_valid && bus.s_ready;
    assign w_rd_fire   = bus.m_valid && bus.m_ready;

    // ------------------------------------------------------ bank state FSMs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                r_bank_st[b] <= EMPTY;
            end
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                r_bank_st[b] <= w_bank_st_nxt[b];
            end
        end
    end

    // A bank is never writable and readable at once, so the write and read
    // updates below never touch the same bank in the same cycle.
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            w_bank_st_nxt[b] = r_bank_st[b];
            if (w_wr_fire && (w_wr_bank == 1'(b))) begin
                if (r_wr_row == 3'd7) begin
                    w_bank_st_nxt[b] = FULL;
                end else if (r_bank_st[b] == EMPTY) begin
                    w_bank_st_nxt[b] = FILL;
                end
            end
            if (w_rd_fire && (w_rd_bank == 1'(b))) begin
                if (r_rd_col == 3'd7) begin
                    w_bank_st_nxt[b] = EMPTY;
                end else if (r_bank_st[b] == FULL) begin
                    w_bank_st_nxt[b] = DRAIN;
                end
            end
        end
    end

    // --------------------------------------------------------------- counters
    // 3-bit counters wrap 7 -> 0 on their own.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_row <= '0;
            r_rd_col <= '0;
        end else begin
            if (w_wr_fire) r_wr_row <= r_wr_row + 3'd1;
            if (w_rd_fire) r_rd_col <= r_rd_col + 3'd1;
        end
    end

    // ------------------------------------------------------------------ banks
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        dct_tr_bank #(
            .DATA_W (DATA_W)
        ) u_bank (
            .clk     (clk),
            .rst     (rst),
            .we      (w_wr_fire && (w_wr_bank == 1'(b))),
            .wr_row  (r_wr_row),
            .wr_data (bus.s_data),
            .rd_col  (r_rd_col),
            .rd_data (w_bank_rd[b])
        );
    end

    // ------------------------------------------------------------ column out
    always_comb begin
        bus.m_data = w_bank_rd[0];
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (w_rd_bank == 1'(b)) bus.m_data = w_bank_rd[b];
        end
    end

    assign bus.m_col  = r_rd_col;
    assign bus.m_last = (r_rd_col == 3'd7);

endmodule : dct_transpose
`default_nettype wire

// File: doc/dct_transpose.md
# dct_transpose

Transpose buffer between the first (row) and second (column) passes of the 8-point 2-D DCT. It accepts one 8-coefficient row of signed row-DCT output per handshake and collects eight rows into an 8x8 block. It then emits the block column by column, so the same combinational 1-D DCT core can run the column pass. Both sides use a valid/ready streaming handshake.

## Interface
- DATA_W, 16: width of each signed coefficient; the data path is bit-exact pass-through.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- s_valid  in  1  input row valid.
- s_ready  out  1  block can accept a row this cycle.
- s_data  in  8 x DATA_W signed  row coefficients; element c is coefficient c of the current row.
- m_valid  out  1  output column valid.
- m_ready  in  1  downstream accepts the column.
- m_data  out  8 x DATA_W signed  column; element r is coefficient m_col of row r.
- m_col  out  3  index of the column currently presented.
- m_last  out  1  high together with m_col == 7.

## Operation
- Storage: one or two 8x8 banks of DATA_W registers. Each bank has a state: EMPTY, FILL, FULL or DRAIN.
- Write side:
  - wr_bank selects the target bank and wr_row (0..7) selects the row.
  - On s_valid && s_ready, s_data is written to row wr_row and wr_row increments.
  - The first write moves the bank EMPTY->FILL.
  - The write with wr_row == 7 moves the bank to FULL, wraps wr_row to 0 and toggles wr_bank.
- s_ready = target bank is EMPTY or FILL.
- Read side:
  - rd_bank selects the source bank and rd_col (0..7) selects the column.
  - m_valid = source bank is FULL or DRAIN.
  - The first m_valid && m_ready handshake moves the bank FULL->DRAIN.
  - On each handshake rd_col increments.
  - The handshake with rd_col == 7 moves the bank to EMPTY, wraps rd_col and toggles rd_bank.
- m_data is a combinational column mux from the registered bank contents. m_col = rd_col; m_last = (rd_col == 7).
- m_data, m_col and m_last must hold stable while m_valid && !m_ready.
- No arithmetic, saturation or sign change: output element r of column j equals input element j of row r, bit for bit.
- Reset mid-operation: all banks go to EMPTY, counters and bank pointers go to 0, and any partially written block is discarded.

## Timing
- Reset values:
  - s_ready = 1.
  - m_valid = 0.
  - m_col = 0.
  - m_last = 0.
  - m_data = 0, because bank registers reset to 0.
- Latency: m_valid rises in the cycle after the handshake of row 7.
- Bank state changes take effect at the next clock edge. A bank freed by the column-7 handshake is writable in the following cycle.
- Simultaneous row-7 write to one bank and column-7 read from the other bank in the same cycle is legal; both transitions apply.
- s_ready depends only on registered state, never combinationally on m_ready.

## Configuration
- DCT_TRANSPOSE_PINGPONG_EN defined:
  - Two banks, with write and read proceeding concurrently.
  - Sustains one row in and one column out per cycle.
  - With m_ready held high, s_ready never drops.
- Undefined:
  - Single bank, so wr_bank and rd_bank are constant 0.
  - s_ready stays low from the cycle after the row-7 handshake until the cycle after the column-7 handshake.
  - Peak throughput is one block per 16 cycles.

## Structure
- Shared package dct_pkg holds:
  - DCT_N = 8.
  - DCT_COEF_W = 16, the default for DATA_W.
  - typedef dct_vec_t, an array of eight signed coefficients.
  - typedef bank_state_e {EMPTY, FILL, FULL, DRAIN}.
- Sub-module dct_tr_bank: one 8x8 register bank with a row-write port (we, row index, vector) and a column-read port (column index, vector). Instantiated once or twice depending on the macro.

## Test plan
- Single block: row r element c = 8r+c, m_ready=1 → eight columns, column j element r = 8r+j. m_col runs 0..7, m_last only with m_col=7, and first m_valid is one cycle after row 7.
- Back-to-back blocks with PINGPONG_EN, s_valid and m_ready held at 1 → s_ready constantly 1. m_valid is continuous for 16 cycles from the first column, and the second block's data is correct.
- Backpressure with m_ready=0:
  - With PINGPONG_EN, s_ready drops after 16 accepted rows.
  - Without it, s_ready drops after 8 rows.
  - m_data stays stable; raising m_ready resumes with no loss or duplication.
- Extremes: rows containing -32768, 32767, -1 and 0 → identical bit patterns appear at the transposed positions.
- Reset after 5 rows accepted → no m_valid. The next 8 rows form a complete block, output correctly starting at column 0.
- Random s_valid/m_ready toggling over 100 blocks against a scoreboard transpose model, under both macro settings.
